// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: FSM state type and default widths shared by ram_pixel_streamer.
package ram_stream_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO for RAM read data plus last flag; clr empties it.
module rd_skid_fifo #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic wp, rp;
   always_ff @(posedge clk)
      if (rst || clr) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) mem[wp] <= din;
         wp    <= wp ^ push;
         rp    <= rp ^ pop;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   assign dout  = mem[rp];
   assign full  = count == 2'd2;
   assign empty = count == 2'd0;
endmodule

// File: rtl/ram_pixel_streamer.sv
// ram_pixel_streamer: streams an image out of a single-port RAM and writes results back.
// Define RAM_STREAMER_STALL_CNT_EN to add the stall_cnt output.
module ram_pixel_streamer
   import ram_stream_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RD_BASE = 0,
   parameter int RD_LEN  = 2048,
   parameter int WR_BASE = 2048,
   parameter int WR_LEN  = 2048
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ram_w_en,
   output logic              ram_r_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_last,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_data
`ifdef RAM_STREAMER_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] RD_N    = CW'(RD_LEN);
   localparam logic [CW-1:0] WR_N    = CW'(WR_LEN);
   localparam logic [CW-1:0] LAST_IX = CW'(RD_LEN - 1);

   state_t state;
   logic [CW-1:0] rd_issued, rd_sent, wr_cnt;
   logic inflight, inflight_last, go, pop, w_fire, r_fire, fempty, ffull;
   logic [1:0] fcount;
   logic [2:0] occ;
   logic [DATA_W:0] fdout;

   assign busy      = state == RUN;
   assign done      = state == FINISH;
   assign go        = start && !busy;
   assign res_ready = busy && wr_cnt < WR_N;
   assign w_fire    = res_valid && res_ready;
   assign pix_valid = !fempty;
   assign pop       = pix_valid && pix_ready;
   // Occupancy after this cycle's pop, so a steady stream issues one read per cycle.
   assign occ       = {1'b0, fcount} + {2'b0, inflight} - {2'b0, pop};
   assign r_fire    = busy && !w_fire && rd_issued < RD_N && occ < 3'd2 && (!ffull || pop);
   assign ram_w_en  = w_fire;
   assign ram_r_en  = r_fire;
   assign ram_addr  = w_fire ? ADDR_W'(WR_BASE) + wr_cnt[ADDR_W-1:0] :
                      r_fire ? ADDR_W'(RD_BASE) + rd_issued[ADDR_W-1:0] : '0;
   assign ram_wdata = w_fire ? res_data : '0;
   assign pix_data  = fdout[DATA_W-1:0];
   assign pix_last  = pix_valid && fdout[DATA_W];

   always_ff @(posedge clk)
      if (rst) begin
         state         <= IDLE;
         rd_issued     <= '0;
         rd_sent       <= '0;
         wr_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= r_fire;
         inflight_last <= r_fire && rd_issued == LAST_IX;
         if (go) begin
            state     <= RUN;
            rd_issued <= '0;
            rd_sent   <= '0;
            wr_cnt    <= '0;
         end else if (busy) begin
            rd_issued <= rd_issued + CW'(r_fire);
            rd_sent   <= rd_sent + CW'(pop);
            wr_cnt    <= wr_cnt + CW'(w_fire);
            if (rd_sent == RD_N && wr_cnt == WR_N) state <= FINISH;
         end
      end

   rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (go),
      .push  (inflight),
      .pop   (pop),
      .din   ({inflight_last, ram_rdata}),
      .dout  (fdout),
      .full  (ffull),
      .empty (fempty),
      .count (fcount)
   );

`ifdef RAM_STREAMER_STALL_CNT_EN
   always_ff @(posedge clk)
      if (rst || go) stall_cnt <= '0;
      else if (busy && pix_valid && !pix_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_ram_pixel_streamer.sv
// tb_ram_pixel_streamer: vector table, abort sequence and randomized jobs against a RAM model.
module tb_ram_pixel_streamer;
   localparam int AW = 12, DW = 8, RB = 4094, RL = 4, WB = 2048, WL = 3;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_ready = 1'b0, res_valid = 1'b0;
   logic [DW-1:0] res_data = '0, ram_rdata, ram_wdata, pix_data;
   logic [AW-1:0] ram_addr;
   logic busy, done, ram_w_en, ram_r_en, pix_valid, pix_last, res_ready;
`ifdef RAM_STREAMER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   ram_pixel_streamer #(.ADDR_W(AW), .DATA_W(DW), .RD_BASE(RB), .RD_LEN(RL), .WR_BASE(WB), .WR_LEN(WL)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef RAM_STREAMER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle read latency; tb_we preloads the image.
   logic [DW-1:0] mem [1 << AW];
   logic tb_we = 1'b0;
   logic [AW-1:0] tb_wa = '0;
   logic [DW-1:0] tb_wd = '0;
   always @(posedge clk) begin
      if (tb_we) mem[tb_wa] <= tb_wd;
      else if (ram_w_en) mem[ram_addr] <= ram_wdata;
      if (ram_r_en) ram_rdata <= mem[ram_addr];
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input int d);
      tb_we = 1'b1;
      tb_wa = AW'(a % (1 << AW));
      tb_wd = DW'(d);
      tick();
      tb_we = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " pix_valid"}, int'(pix_valid), 0);
      chk({tag, " pix_last"}, int'(pix_last), 0);
      chk({tag, " res_ready"}, int'(res_ready), 0);
      chk({tag, " ram_r_en"}, int'(ram_r_en), 0);
      chk({tag, " ram_w_en"}, int'(ram_w_en), 0);
      chk({tag, " ram_addr"}, int'(ram_addr), 0);
      chk({tag, " ram_wdata"}, int'(ram_wdata), 0);
   endtask

   typedef struct {
      logic s, rv, pr;
      logic [7:0] rd;
      logic busy, done, pv, pl, rr, r, w;
      int pd, addr;
   } vec_t;

   function automatic vec_t mk(int s, int rv, int rd, int pr, int bz, int dn, int pv, int pd, int pl,
                               int rr, int r, int w, int addr);
      vec_t v;
      v.s = s[0]; v.rv = rv[0]; v.rd = rd[7:0]; v.pr = pr[0];
      v.busy = bz[0]; v.done = dn[0]; v.pv = pv[0]; v.pd = pd; v.pl = pl[0];
      v.rr = rr[0]; v.r = r[0]; v.w = w[0]; v.addr = addr;
      return v;
   endfunction

   // mode 1 holds pix_ready low for 10 cycles mid-stream; otherwise random ready/valid.
   task automatic run_job(input int mode, input int rpct, input int wpct);
      int iss, got, wrs;
      logic fin, stl, spl;
      logic [7:0] spd;
      logic [7:0] expp [RL];
      logic [7:0] expw [WL];
      for (int i = 0; i < RL; i++) expp[i] = mem[AW'((RB + i) % (1 << AW))];
      iss = 0; got = 0; wrs = 0; fin = 1'b0; stl = 1'b0; spl = 1'b0; spd = '0;
      start = 1'b1; res_valid = 1'b0; pix_ready = 1'b1;
      @(negedge clk);
      chk("job idle busy", int'(busy), 0);
      tick();
      start = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         pix_ready = (mode == 1) ? !(c >= 3 && c < 13) : ($urandom_range(99) < rpct);
         res_valid = $urandom_range(99) < wpct;
         res_data = DW'($urandom);
         @(negedge clk);
         chk("one strobe", int'(ram_r_en && ram_w_en), 0);
         chk("res_ready", int'(res_ready), int'(wrs < WL));
         chk("write priority", int'(ram_w_en), int'(res_valid && wrs < WL));
         if (stl) begin
            chk("stall valid", int'(pix_valid), 1);
            chk("stall data", int'(pix_data), int'(spd));
            chk("stall last", int'(pix_last), int'(spl));
         end
         if (pix_valid && pix_ready) begin
            chk("pix extra", int'(got < RL), 1);
            if (got < RL) begin
               chk("pix data", int'(pix_data), int'(expp[got]));
               chk("pix last", int'(pix_last), int'(got == RL - 1));
            end
            got++;
         end
         if (ram_w_en) begin
            chk("wr addr", int'(ram_addr), (WB + wrs) % (1 << AW));
            chk("wr data", int'(ram_wdata), int'(res_data));
            if (wrs < WL) expw[wrs] = res_data;
            wrs++;
         end
         if (ram_r_en) begin
            chk("rd addr", int'(ram_addr), (RB + iss) % (1 << AW));
            chk("outstanding", int'(iss + 1 - got <= 2), 1);
            iss++;
         end
         stl = pix_valid && !pix_ready;
         spd = pix_data;
         spl = pix_last;
         fin = done;
         tick();
      end
      chk("job done", int'(fin), 1);
      chk("pix count", got, RL);
      chk("wr count", wrs, WL);
      for (int k = 0; k < WL; k++) chk("ram result", int'(mem[AW'(WB + k)]), int'(expw[k]));
      res_valid = 1'b0;
   endtask

   initial begin
      vec_t tab [13];
      int n;
      tab[0]  = mk(1, 0, 0, 1,    0, 0, 0, 0, 0,  0, 0, 0, 0);
      tab[1]  = mk(0, 0, 0, 1,    1, 0, 0, 0, 0,  1, 1, 0, 4094);
      tab[2]  = mk(0, 0, 0, 1,    1, 0, 0, 0, 0,  1, 1, 0, 4095);
      tab[3]  = mk(0, 0, 0, 1,    1, 0, 1, 10, 0, 1, 1, 0, 0);
      tab[4]  = mk(0, 0, 0, 1,    1, 0, 1, 20, 0, 1, 1, 0, 1);
      tab[5]  = mk(0, 0, 0, 1,    1, 0, 1, 30, 0, 1, 0, 0, 0);
      tab[6]  = mk(0, 0, 0, 1,    1, 0, 1, 40, 1, 1, 0, 0, 0);
      tab[7]  = mk(0, 1, 'hA5, 1, 1, 0, 0, 0, 0,  1, 0, 1, 2048);
      tab[8]  = mk(0, 1, 'h3C, 1, 1, 0, 0, 0, 0,  1, 0, 1, 2049);
      tab[9]  = mk(0, 1, 'hC3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 2050);
      tab[10] = mk(0, 0, 0, 1,    1, 0, 0, 0, 0,  0, 0, 0, 0);
      tab[11] = mk(0, 0, 0, 1,    0, 1, 0, 0, 0,  0, 0, 0, 0);
      tab[12] = mk(0, 0, 0, 1,    0, 1, 0, 0, 0,  0, 0, 0, 0);

      repeat (3) tick();
      @(negedge clk);
      chk_rst("rst held");
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_rst("post rst");
      tick();
      load(4094, 10); load(4095, 20); load(0, 30); load(1, 40);

      for (int i = 0; i < 13; i++) begin
         start = tab[i].s; res_valid = tab[i].rv; res_data = tab[i].rd; pix_ready = tab[i].pr;
         @(negedge clk);
         chk($sformatf("v%0d busy", i), int'(busy), int'(tab[i].busy));
         chk($sformatf("v%0d done", i), int'(done), int'(tab[i].done));
         chk($sformatf("v%0d pix_valid", i), int'(pix_valid), int'(tab[i].pv));
         chk($sformatf("v%0d pix_last", i), int'(pix_last), int'(tab[i].pl));
         chk($sformatf("v%0d res_ready", i), int'(res_ready), int'(tab[i].rr));
         chk($sformatf("v%0d ram_r_en", i), int'(ram_r_en), int'(tab[i].r));
         chk($sformatf("v%0d ram_w_en", i), int'(ram_w_en), int'(tab[i].w));
         chk($sformatf("v%0d ram_addr", i), int'(ram_addr), tab[i].addr);
         chk($sformatf("v%0d ram_wdata", i), int'(ram_wdata), tab[i].w ? int'(tab[i].rd) : 0);
         if (tab[i].pv) chk($sformatf("v%0d pix_data", i), int'(pix_data), tab[i].pd);
         tick();
      end
      start = 1'b0; res_valid = 1'b0;

      // Abort after three reads, then the first random job must re-read from RD_BASE.
      start = 1'b1; pix_ready = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n += int'(ram_r_en);
         tick();
      end
      chk("abort reads", n, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_rst("after abort");
      tick();
      @(negedge clk);
      chk("abort discard", int'(pix_valid), 0);
      tick();

      run_job(0, 100, 100);
      run_job(1, 0, 10);
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < RL; i++) load(RB + i, int'($urandom_range(255)));
         run_job(0, int'($urandom_range(100, 20)), int'($urandom_range(90, 10)));
      end

`ifdef RAM_STREAMER_STALL_CNT_EN
      start = 1'b1; pix_ready = 1'b0; res_valid = 1'b0;
      tick();
      start = 1'b0;
      n = 0;
      for (int k = 0; k < 10 && n == 0; k++) begin
         @(negedge clk);
         n = int'(pix_valid);
         if (n == 0) tick();
      end
      chk("stall wait valid", n, 1);
      repeat (7) tick();
      @(negedge clk);
      chk("stall_cnt", int'(stall_cnt), 7);
      tick();
      pix_ready = 1'b1; res_valid = 1'b1;
      n = 0;
      for (int k = 0; k < 50 && n == 0; k++) begin
         @(negedge clk);
         n = int'(done);
         tick();
      end
      chk("stall job done", n, 1);
      res_valid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
